// File: rtl/fetch_unit_q.sv
`default_nettype none
//============================================================================
// Module   : fetch_unit_q
// Brief    : Instruction fetch unit with prefetch queue, branch hold and
//            redirect. Define FETCH_PERF_EN to add perf counter ports.
// Revision : 1.0 - initial release
//============================================================================
module fetch_unit_q #(
    parameter int                      PC_W     = 7,
    parameter int                      INSTR_W  = 32,
    parameter int                      DEPTH    = 4,
    parameter logic [PC_W-1:0]         RESET_PC = '0,
    parameter int                      OPC_HI   = 31,
    parameter int                      OPC_LO   = 26,
    parameter logic [OPC_HI-OPC_LO:0]  BR_OPC   = 6'b000100
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redir_valid,
    input  logic [PC_W-1:0]    redir_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic               bubble
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_bubble,
    output logic [15:0]        perf_flush
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic                 r_inflight;
    logic                 r_infl_epoch;
    logic                 r_epoch;
    logic [PC_W-1:0]      r_infl_pc;
    logic [INSTR_W-1:0]   r_q_instr [DEPTH];
    logic [PC_W-1:0]      r_q_pc    [DEPTH];

    logic                 w_ret_live;
    logic                 w_ret_branch;
    logic                 w_enq;
    logic                 w_deq;
    logic                 w_issue;
    logic [c_CNT_W-1:0]   w_occ;

    // A returning word only counts if it was issued in the current epoch.
    assign w_ret_live   = r_inflight && (r_infl_epoch == r_epoch);
    assign w_ret_branch = w_ret_live && (imem_rdata[OPC_HI:OPC_LO] == BR_OPC);
    assign w_enq        = w_ret_live && !redir_valid && !rst;
    assign w_deq        = out_valid && out_ready;
    assign w_occ        = r_count + c_CNT_W'(r_inflight);

    // Branch returning this cycle blocks the issue of the next sequential PC.
    assign w_issue = !rst && (r_state == ST_RUN) && !redir_valid &&
                     !w_ret_branch && (w_occ < c_DEPTH);

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign out_valid = (r_count != '0);
    assign out_instr = r_q_instr[r_rd_ptr];
    assign out_pc    = r_q_pc[r_rd_ptr];
    assign bubble    = !rst && (r_state == ST_HOLD) && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_inflight   <= 1'b0;
            r_infl_epoch <= 1'b0;
            r_epoch      <= 1'b0;
            r_infl_pc    <= RESET_PC;
        end else if (redir_valid) begin
            r_state    <= ST_RUN;
            r_pc       <= redir_pc;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_epoch    <= ~r_epoch;
        end else begin
            r_inflight   <= w_issue;
            r_infl_epoch <= r_epoch;
            if (w_issue) begin
                r_pc      <= r_pc + PC_W'(1);
                r_infl_pc <= r_pc;
            end
            if (w_ret_branch) begin
                r_state <= ST_HOLD;
            end
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            r_count <= r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_infl_pc;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch  <= '0;
            perf_bubble <= '0;
            perf_flush  <= '0;
        end else begin
            if (w_issue && (perf_fetch != 16'hFFFF)) begin
                perf_fetch <= perf_fetch + 16'd1;
            end
            if (bubble && (perf_bubble != 16'hFFFF)) begin
                perf_bubble <= perf_bubble + 16'd1;
            end
            if (redir_valid && (perf_flush != 16'hFFFF)) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_q.sv
`default_nettype none
//============================================================================
// Module   : tb_fetch_unit_q
// Brief    : Scoreboard bench for fetch_unit_q (RESET_PC=0 and RESET_PC=126).
// Revision : 1.0 - initial release
//============================================================================
module tb_fetch_unit_q;

    typedef struct packed {
        logic [6:0]  pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [6:0]  imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        redir_valid = 1'b0;
    logic [6:0]  redir_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [6:0]  out_pc;
    logic        bubble;

    logic        rst2 = 1'b1;
    logic        imem_en2;
    logic [6:0]  imem_addr2;
    logic [31:0] imem_rdata2 = 32'hDEAD_BEEF;
    logic        out_valid2;
    logic        out_ready2 = 1'b0;
    logic [31:0] out_instr2;
    logic [6:0]  out_pc2;
    logic        bubble2;
    logic        redir_valid2 = 1'b0;
    logic [6:0]  redir_pc2 = '0;

`ifdef FETCH_PERF_EN
    logic [15:0] pf1, pb1, pl1, pf2, pb2, pl2;
`endif

    int   total = 0;
    int   bad = 0;
    int   accepted = 0;
    int   accepted2 = 0;
    exp_t exp_q[$];
    exp_t exp2_q[$];
    logic [6:0] iss_q[$];
    logic [6:0] iss2_q[$];
    logic       br_en = 1'b0;
    logic [6:0] br_addr = '0;

    always #5 clk = ~clk;

    fetch_unit_q dut (
        .clk(clk), .rst(rst),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .bubble(bubble)
`ifdef FETCH_PERF_EN
        , .perf_fetch(pf1), .perf_bubble(pb1), .perf_flush(pl1)
`endif
    );

    fetch_unit_q #(.RESET_PC(7'd126)) dut2 (
        .clk(clk), .rst(rst2),
        .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redir_valid(redir_valid2), .redir_pc(redir_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_pc(out_pc2), .bubble(bubble2)
`ifdef FETCH_PERF_EN
        , .perf_fetch(pf2), .perf_bubble(pb2), .perf_flush(pl2)
`endif
    );

    function automatic logic [31:0] word_of(input logic [6:0] a);
        if (br_en && (a == br_addr)) return {6'b000100, 19'b0, a};
        return {25'b0, a};
    endfunction

    // Instruction memories: 1-cycle synchronous read.
    always @(posedge clk) begin
        imem_rdata  <= imem_en  ? word_of(imem_addr) : 32'hDEAD_BEEF;
        imem_rdata2 <= imem_en2 ? {25'b0, imem_addr2} : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        if (imem_en && !rst) iss_q.push_back(imem_addr);
        if (imem_en2 && !rst2) iss2_q.push_back(imem_addr2);
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            total++;
            accepted++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL out_unexpected actual pc=%0h instr=%0h required=none", out_pc, out_instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_pc !== e.pc || out_instr !== e.instr) begin
                    bad++;
                    $display("FAIL out_word actual pc=%0h instr=%0h required pc=%0h instr=%0h",
                             out_pc, out_instr, e.pc, e.instr);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid2 && out_ready2) begin
            total++;
            accepted2++;
            if (exp2_q.size() == 0) begin
                bad++;
                $display("FAIL out2_unexpected actual pc=%0h required=none", out_pc2);
            end else begin
                exp_t e;
                e = exp2_q.pop_front();
                if (out_pc2 !== e.pc || out_instr2 !== e.instr) begin
                    bad++;
                    $display("FAIL out2_word actual pc=%0h instr=%0h required pc=%0h instr=%0h",
                             out_pc2, out_instr2, e.pc, e.instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_iss(input string name, input int idx, input logic [6:0] req);
        if (idx < iss_q.size()) chk(name, {25'b0, iss_q[idx]}, {25'b0, req});
        else begin
            total++;
            bad++;
            $display("FAIL %s actual=missing required=%0h", name, req);
        end
    endtask

    task automatic push_exp(input logic [6:0] pc, input logic [31:0] instr);
        exp_q.push_back('{pc: pc, instr: instr});
    endtask

    task automatic wait_acc(input string name, input int target);
        int n = 0;
        while (accepted < target && n < 60) begin
            tick();
            n++;
        end
        total++;
        if (accepted < target) begin
            bad++;
            $display("FAIL %s timeout accepted=%0d required=%0d", name, accepted, target);
        end
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        redir_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_rst();
        rst = 1'b0;
        iss_q.delete();
    endtask

    initial begin
        int base;
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_imem_en", imem_en, 0);
        chk("rst_imem_addr", imem_addr, 0);

        // Streaming, word = address
        base = accepted;
        for (int i = 0; i < 8; i++) push_exp(7'(i), 32'(i));
        out_ready = 1'b1;
        tick();
        release_rst();
        @(negedge clk);
        chk("c0_imem_en", imem_en, 1);
        chk("c0_imem_addr", imem_addr, 0);
        chk("c0_out_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("c1_out_valid", out_valid, 0);
        tick();
        @(negedge clk);
        chk("c2_out_valid", out_valid, 1);
        chk("c2_bubble", bubble, 0);
        wait_acc("stream", base + 8);
        out_ready = 1'b0;

        // Backpressure: exactly 4 issues
        do_reset();
        release_rst();
        repeat (8) tick();
        @(negedge clk);
        chk("bp_issue_count", iss_q.size(), 4);
        for (int i = 0; i < 4; i++) chk_iss("bp_issue_addr", i, 7'(i));
        chk("bp_imem_en", imem_en, 0);
        chk("bp_out_pc", out_pc, 0);
        chk("bp_out_valid", out_valid, 1);
        tick();
        base = accepted;
        for (int i = 0; i < 6; i++) push_exp(7'(i), 32'(i));
        out_ready = 1'b1;
        wait_acc("bp_resume", base + 6);
        out_ready = 1'b0;
        chk_iss("bp_resume_addr", 4, 7'd4);

        // Branch at 5: hold, bubble, redirect to 0x40
        do_reset();
        br_en = 1'b1;
        br_addr = 7'd5;
        base = accepted;
        for (int i = 0; i < 5; i++) push_exp(7'(i), 32'(i));
        push_exp(7'd5, 32'h1000_0005);
        for (int i = 0; i < 4; i++) push_exp(7'(8'h40 + i), 32'(8'h40 + i));
        out_ready = 1'b1;
        release_rst();
        wait_acc("br_drain", base + 6);
        repeat (3) tick();
        @(negedge clk);
        chk("br_bubble", bubble, 1);
        chk("br_out_valid", out_valid, 0);
        chk("br_imem_en", imem_en, 0);
        chk("br_issue_count", iss_q.size(), 6);
        tick();
        redir_valid = 1'b1;
        redir_pc = 7'h40;
        @(negedge clk);
        chk("br_redir_imem_en", imem_en, 0);
        tick();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("br_post_bubble", bubble, 0);
        chk("br_post_imem_en", imem_en, 1);
        chk("br_post_imem_addr", imem_addr, 32'h40);
        wait_acc("br_redirect", base + 10);
        out_ready = 1'b0;
        br_en = 1'b0;

        // Redirect while addr 3 in flight
        do_reset();
        base = accepted;
        for (int i = 0; i < 3; i++) push_exp(7'(i), 32'(i));
        for (int i = 0; i < 3; i++) push_exp(7'(8'h10 + i), 32'(8'h10 + i));
        out_ready = 1'b1;
        release_rst();
        repeat (4) tick();
        redir_valid = 1'b1;
        redir_pc = 7'h10;
        @(negedge clk);
        chk("rd_imem_en", imem_en, 0);
        tick();
        redir_valid = 1'b0;
        wait_acc("rd_flush", base + 6);
        out_ready = 1'b0;
        chk_iss("rd_issue3", 3, 7'd3);
        chk_iss("rd_issue_target", 4, 7'h10);

        // Reset during HOLD with 3 queued entries
        do_reset();
        br_en = 1'b1;
        br_addr = 7'd2;
        release_rst();
        repeat (6) tick();
        @(negedge clk);
        chk("hr_out_valid", out_valid, 1);
        chk("hr_issue_count", iss_q.size(), 3);
        chk("hr_imem_en", imem_en, 0);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("hr_rst_out_valid", out_valid, 0);
        chk("hr_rst_bubble", bubble, 0);
        chk("hr_rst_imem_addr", imem_addr, 0);
        br_en = 1'b0;

        // RESET_PC = 126 wraps through 127 -> 0
        exp2_q.push_back('{pc: 7'd126, instr: 32'd126});
        exp2_q.push_back('{pc: 7'd127, instr: 32'd127});
        exp2_q.push_back('{pc: 7'd0, instr: 32'd0});
        exp2_q.push_back('{pc: 7'd1, instr: 32'd1});
        out_ready2 = 1'b1;
        rst2 = 1'b0;
        iss2_q.delete();
        begin
            int n = 0;
            while (accepted2 < 4 && n < 40) begin
                tick();
                n++;
            end
        end
        out_ready2 = 1'b0;
        chk("wrap_accepted", accepted2, 4);
        if (iss2_q.size() >= 4) begin
            chk("wrap_iss0", iss2_q[0], 126);
            chk("wrap_iss1", iss2_q[1], 127);
            chk("wrap_iss2", iss2_q[2], 0);
            chk("wrap_iss3", iss2_q[3], 1);
        end else begin
            total++;
            bad++;
            $display("FAIL wrap_issue_count actual=%0d required=4", iss2_q.size());
        end

        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp2_q_empty", exp2_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit_q.md
Name: fetch_unit_q

Overview:
Parametrised instruction fetch unit, next generation of the pipeline fetch stage. Drives a synchronous instruction memory with 1-cycle read latency and buffers returned words in a prefetch queue. Presents instructions to decode with a valid/ready handshake. Detects branch-class opcodes, holds fetch until decode/execute supplies a redirect, and flags bubbles; sits between the PC source and the decode latch.

Parameters:
PC_W, 7, program counter / instruction memory address width
INSTR_W, 32, instruction word width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 0, PC value loaded on reset
OPC_HI, 31, MSB of opcode field in instruction
OPC_LO, 26, LSB of opcode field
BR_OPC, 6'b000100, opcode value marking a branch/jump

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
imem_en  out  1  memory read strobe
imem_addr  out  PC_W  memory read address
imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_en
redir_valid  in  1  redirect request (taken branch / jump resolved)
redir_pc  in  PC_W  redirect target
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head
out_instr  out  INSTR_W  head instruction
out_pc  out  PC_W  address of head instruction
bubble  out  1  high while out_valid=0 because fetch is held on a branch

Behaviour:
- Reset: PC<=RESET_PC, queue empty, in-flight cleared, state RUN; out_valid=0, bubble=0, imem_en=0, imem_addr=RESET_PC. rst mid-operation discards queue and in-flight read; rst overrides redir_valid.
- States: RUN (issuing), HOLD (branch seen, no issue). RUN->HOLD when a returned word has opcode[OPC_HI:OPC_LO]==BR_OPC (word itself is enqueued). HOLD->RUN only on redir_valid. redir_valid in RUN also honoured (exception/mispredict).
- Issue rule: imem_en=1 iff state RUN, no redirect this cycle, and (count + inflight) < DEPTH. On issue: imem_addr=PC, PC<=PC+1 modulo 2^PC_W (127->0 wraps silently at PC_W=7).
- Return: word captured on cycle after issue with its address, enqueued unless discarded. Branch detection on the returned word: same-cycle issue is suppressed by a combinational check, so no address after the branch is ever fetched.
- Queue: FIFO, head drives out_instr/out_pc; out_valid=(count!=0). Dequeue when out_valid&out_ready. Enqueue and dequeue same cycle: count unchanged. Never full-overflow by construction of issue rule.
- Redirect: on redir_valid, queue flushed, any in-flight return discarded (epoch bit toggles; return tagged with old epoch dropped), PC<=redir_pc, state<=RUN; first issue of redir_pc on next cycle, out_valid earliest 2 cycles after redirect. A handshake completing in the redirect cycle counts as consumed.
- bubble=1 iff state HOLD and count==0; registered-free combinational from state and count; 0 during reset.
- Latency: reset release -> first out_valid = 2 cycles; sustained throughput 1 instr/cycle with out_ready=1.

Optional Feature:
FETCH_PERF_EN: when defined, adds 16-bit saturating counters perf_fetch (issues), perf_bubble (cycles with bubble=1), perf_flush (redirects), cleared by rst, exposed as extra output ports perf_fetch/perf_bubble/perf_flush. When undefined, ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then memory word = address, out_ready=1 -> out_valid at cycle 2, out_pc/out_instr 0,1,2,3... one per cycle, bubble=0.
- out_ready=0 from start -> exactly 4 issues (addr 0..3), imem_en=0 thereafter, out_pc=0 held; raise out_ready -> resumes with addr 4.
- Word at addr 5 has BR_OPC -> addr 6 never issued, after queue drains bubble=1; redir_valid with redir_pc=0x40 -> bubble=0, next out_pc=0x40.
- redir_valid to 0x10 on cycle an issue of addr 3 is in flight -> addr 3 data never appears, next out_pc=0x10.
- RESET_PC=126 -> issued addresses 126,127,0,1; out_pc follows same order.
- rst asserted with 3 queued entries and HOLD state -> next cycle out_valid=0, bubble=0, imem_addr=RESET_PC.
